word_to_byte_unpacker: RTL and testbench
========================================

Name: word_to_byte_unpacker

Overview:
- Opposite direction of test_partial_module's byte-in/word-out datapath: accepts 16-bit words and emits them as a stream of 8-bit bytes.
- Sits downstream of a test_partial_module data_out.
- Word-side handshake uses the same enable/ready naming; byte side is valid/ready.
- Small word FIFO decouples the producer from a stalling byte consumer.

Parameters:
- DEPTH, 2, word FIFO entries; power of two, >= 2.
- LOW_FIRST, 0, 0 = emit bits [15:8] first, 1 = emit bits [7:0] first.
- COUNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (low = in reset).
- data_in  input  16  word from upstream.
- enable  input  1  data_in valid.
- ready  output  1  FIFO can accept a word.
- data_out  output  8  current byte.
- out_valid  output  1  data_out valid.
- out_ready  input  1  consumer accepts byte.
- status  output  4  [0] busy, [1] fifo full, [2] sticky drop, [3] second byte presented.
- word_count  output  COUNT_W  words fully emitted, wraps.

Behaviour:
- Reset (async assert, sync release): FIFO empty, phase=0, word_count=0, status=4'b0000.
  - ready=0 while reset is low; ready=1 from the first cycle after release.
  - out_valid=0 and data_out=8'h00 during reset.
- Push:
  - enable && ready at a rising edge writes data_in to the tail.
  - ready = !full, decoded from registered occupancy.
  - When full, a push is rejected even if a pop completes in the same cycle (no pass-through).
- Drop:
  - enable && !ready (post-reset) sets status[2].
  - status[2] is cleared only by reset.
- Output:
  - out_valid = FIFO not empty.
  - data_out = byte of the head word selected by phase XOR LOW_FIRST: phase 0 is the first byte, phase 1 the second.
  - data_out = 8'h00 when empty.
- Latency: a word pushed at edge N gives out_valid=1 in the cycle after edge N; minimum 2 byte-cycles per word.
- Byte FSM, on each accepted byte (out_valid && out_ready):
  - FIRST (phase=0) -> SECOND (phase=1).
  - SECOND -> FIRST, with the head popped and word_count incremented (wraps to 0 at 2^COUNT_W).
- Stall: while out_ready=0, data_out, out_valid and phase hold.
- Simultaneous push and final-byte pop (not full): occupancy unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits, wrap naturally; occupancy is log2(DEPTH)+1 bits.
- status bits:
  - [0] busy = !empty.
  - [1] = full.
  - [3] = phase && out_valid.
- Reset mid-word: partial word discarded, phase returns to 0, no count increment.

Optional Feature:
- Macro UNPACK_PARITY_EN.
- Defined:
  - Extra output port out_parity (1 bit) = even parity (XOR) of data_out, valid with out_valid, 0 when empty.
  - Extra input port in_parity (1 bit), checked on push against the XOR of data_in; a mismatch sets sticky status[2] (shared with drop).
- Undefined: ports absent; status[2] reflects drops only.

Decomposition:
- Shared package:
  - byte-phase enum (PH_FIRST, PH_SECOND).
  - status bit index constants (ST_BUSY=0, ST_FULL=1, ST_DROP=2, ST_SECOND=3).
  - Word and byte width constants (16, 8).
- One natural sub-module: unpack_word_fifo, a synchronous DEPTH x 16 FIFO with full/empty/occupancy and the same clk/reset.
- FSM, mux and counter stay in the top.

Test Plan:
- Reset then push 16'hA55A with out_ready=1, LOW_FIRST=0 -> bytes 8'hA5 then 8'h5A on consecutive cycles; word_count=1; status[3]=1 only on the 8'h5A cycle.
- LOW_FIRST=1, push 16'h1234 -> bytes 8'h34 then 8'h12.
- Hold out_ready=0, push 3 words with DEPTH=2 -> ready=0 after the 2nd push; 3rd push sets status[2]=1, status[1]=1. Release out_ready -> bytes of words 1 and 2 only; status[2] stays 1.
- Back-to-back pushes with out_ready=1 -> continuous byte stream, no bubbles; out_valid high throughout; word_count increments every 2 cycles.
- Assert reset after the first byte of 16'hBEEF -> out_valid=0, word_count=0, status=0 immediately. After release, push 16'h0102 -> 8'h01 first.
- Stream 256 words with COUNT_W=8 -> word_count wraps to 8'h00. With UNPACK_PARITY_EN: out_parity=1 for byte 8'h07; push with wrong in_parity sets status[2].

Source files
------------

// File: rtl/word_to_byte_unpacker_pkg.sv
// Shared types and constants for the 16-bit word to 8-bit byte unpacker.
// Optional parity support is enabled with the UNPACK_PARITY_EN macro.
package word_to_byte_unpacker_pkg;

  localparam int WORD_W   = 16;
  localparam int BYTE_W   = 8;
  localparam int STATUS_W = 4;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_DROP   = 2;
  localparam int ST_SECOND = 3;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  // sel=0 returns bits [15:8], sel=1 returns bits [7:0].
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w, input logic sel);
    return sel ? w[BYTE_W-1:0] : w[WORD_W-1:BYTE_W];
  endfunction

endpackage

// File: rtl/word_to_byte_unpacker_if.sv
// Word-in / byte-out bus of the unpacker; parity signals exist only with UNPACK_PARITY_EN.
interface word_to_byte_unpacker_if #(
  parameter int COUNT_W = 8
);
  import word_to_byte_unpacker_pkg::*;

  // Word side: a word transfers on a rising edge where enable && ready.
  // Byte side: a byte transfers on a rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready and data_out holds while stalled.
  logic [WORD_W-1:0]   data_in;
  logic                enable;
  logic                ready;
  logic [BYTE_W-1:0]   data_out;
  logic                out_valid;
  logic                out_ready;
  logic [STATUS_W-1:0] status;
  logic [COUNT_W-1:0]  word_count;
`ifdef UNPACK_PARITY_EN
  logic                in_parity;
  logic                out_parity;

  modport slave (
    input  data_in, enable, out_ready, in_parity,
    output ready, data_out, out_valid, status, word_count, out_parity
  );
  modport master (
    output data_in, enable, out_ready, in_parity,
    input  ready, data_out, out_valid, status, word_count, out_parity
  );
`else
  modport slave (
    input  data_in, enable, out_ready,
    output ready, data_out, out_valid, status, word_count
  );
  modport master (
    output data_in, enable, out_ready,
    input  ready, data_out, out_valid, status, word_count
  );
`endif

endinterface

// File: rtl/word_to_byte_unpacker_fifo.sv
// Synchronous DEPTH x 16 word FIFO with registered occupancy; push is ignored when full,
// pop is ignored when empty.
module unpack_word_fifo
  import word_to_byte_unpacker_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [PTR_W:0]    o_count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/word_to_byte_unpacker.sv
// Buffers 16-bit words and emits each as two bytes (order set by LOW_FIRST).
// UNPACK_PARITY_EN adds out_parity and an in_parity check folded into the sticky drop flag.
module word_to_byte_unpacker
  import word_to_byte_unpacker_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit LOW_FIRST = 1'b0,
  parameter int COUNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  word_to_byte_unpacker_if.slave        bus,
  output phase_e                        o_dbg_phase
);

  localparam int PTR_W = $clog2(DEPTH);

  logic                r_alive;
  logic                r_drop;
  phase_e              r_phase;
  phase_e              w_phase_nxt;
  logic [COUNT_W-1:0]  r_word_count;

  logic [WORD_W-1:0]   w_head;
  logic                w_full;
  logic                w_empty;
  logic [PTR_W:0]      w_occ;
  logic                w_push;
  logic                w_accept;
  logic                w_pop;
  logic                w_sel;
  logic                w_drop_evt;
  logic [STATUS_W-1:0] w_status;

  unpack_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.data_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  // ready is low until the first edge after reset release, then tracks the registered full flag.
  assign bus.ready = r_alive && !w_full;
  assign w_push    = bus.enable && bus.ready;
  assign w_accept  = !w_empty && bus.out_ready;
  assign w_sel     = logic'(r_phase) ^ LOW_FIRST;

  assign bus.out_valid  = !w_empty;
  assign bus.data_out   = w_empty ? '0 : pick_byte(w_head, w_sel);
  assign bus.word_count = r_word_count;
  assign bus.status     = w_status;
  assign o_dbg_phase    = r_phase;

`ifdef UNPACK_PARITY_EN
  assign bus.out_parity = ^bus.data_out;
  assign w_drop_evt = (bus.enable && !bus.ready && r_alive) ||
                      (w_push && (bus.in_parity != ^bus.data_in));
`else
  assign w_drop_evt = bus.enable && !bus.ready && r_alive;
`endif

  always_comb begin
    w_phase_nxt = r_phase;
    w_pop       = 1'b0;
    case (r_phase)
      PH_FIRST: begin
        if (w_accept) w_phase_nxt = PH_SECOND;
      end
      PH_SECOND: begin
        if (w_accept) begin
          w_phase_nxt = PH_FIRST;
          w_pop       = 1'b1;
        end
      end
      default: w_phase_nxt = PH_FIRST;
    endcase
  end

  always_comb begin
    w_status            = '0;
    w_status[ST_BUSY]   = (w_occ != '0);
    w_status[ST_FULL]   = w_full;
    w_status[ST_DROP]   = r_drop;
    w_status[ST_SECOND] = (r_phase == PH_SECOND) && !w_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alive      <= 1'b0;
      r_drop       <= 1'b0;
      r_phase      <= PH_FIRST;
      r_word_count <= '0;
    end else begin
      r_alive <= 1'b1;
      r_phase <= w_phase_nxt;
      if (w_drop_evt) r_drop <= 1'b1;
      if (w_pop)      r_word_count <= r_word_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_word_to_byte_unpacker.sv
// Directed bench for word_to_byte_unpacker: two instances (high-byte-first and low-byte-first).
// Parity checks are compiled in with UNPACK_PARITY_EN.
module tb_word_to_byte_unpacker;
  import word_to_byte_unpacker_pkg::*;

  logic   clk;
  logic   reset;
  phase_e hi_phase;
  phase_e lo_phase;
  logic   par_flip;
  int     n_vec;
  int     n_err;

  word_to_byte_unpacker_if #(.COUNT_W(8)) hi_if ();
  word_to_byte_unpacker_if #(.COUNT_W(8)) lo_if ();

  word_to_byte_unpacker #(.DEPTH(2), .LOW_FIRST(1'b0), .COUNT_W(8)) u_hi (
    .clk         (clk),
    .reset       (reset),
    .bus         (hi_if.slave),
    .o_dbg_phase (hi_phase)
  );

  word_to_byte_unpacker #(.DEPTH(2), .LOW_FIRST(1'b1), .COUNT_W(8)) u_lo (
    .clk         (clk),
    .reset       (reset),
    .bus         (lo_if.slave),
    .o_dbg_phase (lo_phase)
  );

`ifdef UNPACK_PARITY_EN
  assign hi_if.in_parity = (^hi_if.data_in) ^ par_flip;
  assign lo_if.in_parity = ^lo_if.data_in;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] words [4];
    logic [15:0] w;

    n_vec    = 0;
    n_err    = 0;
    par_flip = 1'b0;
    reset    = 1'b0;
    hi_if.data_in = '0; hi_if.enable = 1'b0; hi_if.out_ready = 1'b0;
    lo_if.data_in = '0; lo_if.enable = 1'b0; lo_if.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_ready",     32'(hi_if.ready),      32'h0);
    chk("rst_out_valid", 32'(hi_if.out_valid),  32'h0);
    chk("rst_data_out",  32'(hi_if.data_out),   32'h00);
    chk("rst_status",    32'(hi_if.status),     32'h0);
    chk("rst_count",     32'(hi_if.word_count), 32'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_ready", 32'(hi_if.ready), 32'h1);

    // A55A, high byte first
    hi_if.enable = 1'b1; hi_if.data_in = 16'hA55A; hi_if.out_ready = 1'b1;
    tick();
    hi_if.enable = 1'b0;
    chk("t1_valid0",  32'(hi_if.out_valid), 32'h1);
    chk("t1_byte0",   32'(hi_if.data_out),  32'hA5);
    chk("t1_status0", 32'(hi_if.status),    32'h1);
    tick();
    chk("t1_byte1",   32'(hi_if.data_out),  32'h5A);
    chk("t1_status1", 32'(hi_if.status),    32'h9);
    chk("t1_phase",   32'(hi_phase),        32'(PH_SECOND));
    chk("t1_count0",  32'(hi_if.word_count), 32'h0);
    tick();
    chk("t1_valid_end", 32'(hi_if.out_valid),  32'h0);
    chk("t1_count1",    32'(hi_if.word_count), 32'h1);
    chk("t1_status_end",32'(hi_if.status),     32'h0);

    // 1234, low byte first
    lo_if.enable = 1'b1; lo_if.data_in = 16'h1234; lo_if.out_ready = 1'b1;
    tick();
    lo_if.enable = 1'b0;
    chk("t2_byte0", 32'(lo_if.data_out), 32'h34);
    tick();
    chk("t2_byte1", 32'(lo_if.data_out), 32'h12);
    tick();
    chk("t2_count", 32'(lo_if.word_count), 32'h1);
    chk("t2_valid", 32'(lo_if.out_valid),  32'h0);

    // fill while stalled, third push dropped
    hi_if.out_ready = 1'b0;
    hi_if.enable = 1'b1; hi_if.data_in = 16'h1A2B;
    tick();
    hi_if.data_in = 16'h3C4D;
    tick();
    chk("t3_ready_full", 32'(hi_if.ready),  32'h0);
    chk("t3_full",       32'(hi_if.status[ST_FULL]), 32'h1);
    hi_if.data_in = 16'h5E6F;
    tick();
    hi_if.enable = 1'b0;
    chk("t3_status_drop", 32'(hi_if.status),   32'h7);
    chk("t3_stall_byte",  32'(hi_if.data_out), 32'h1A);
    chk("t3_stall_ready", 32'(hi_if.ready),    32'h0);
    tick();
    chk("t3_hold_byte",   32'(hi_if.data_out), 32'h1A);
    hi_if.out_ready = 1'b1;
    tick();
    chk("t3_w1_lo",      32'(hi_if.data_out), 32'h2B);
    chk("t3_status_sec", 32'(hi_if.status),   32'hF);
    tick();
    chk("t3_w2_hi",      32'(hi_if.data_out),   32'h3C);
    chk("t3_count2",     32'(hi_if.word_count), 32'h2);
    chk("t3_ready_back", 32'(hi_if.ready),      32'h1);
    chk("t3_status_one", 32'(hi_if.status),     32'h5);
    tick();
    chk("t3_w2_lo", 32'(hi_if.data_out), 32'h4D);
    tick();
    chk("t3_empty",       32'(hi_if.out_valid),  32'h0);
    chk("t3_count3",      32'(hi_if.word_count), 32'h3);
    chk("t3_drop_sticky", 32'(hi_if.status),     32'h4);

    // back-to-back words, no bubbles
    words[0] = 16'hC0DE; words[1] = 16'hFACE; words[2] = 16'h0BAD; words[3] = 16'hD00D;
    for (int k = 0; k < 4; k++) begin
      hi_if.enable = 1'b1; hi_if.data_in = words[k];
      tick();
      hi_if.enable = 1'b0;
      chk("t4_valid_a", 32'(hi_if.out_valid),  32'h1);
      chk("t4_hi",      32'(hi_if.data_out),   32'(words[k][15:8]));
      chk("t4_count",   32'(hi_if.word_count), 32'(3 + k));
      tick();
      chk("t4_valid_b", 32'(hi_if.out_valid),  32'h1);
      chk("t4_lo",      32'(hi_if.data_out),   32'(words[k][7:0]));
    end
    tick();
    chk("t4_end_valid", 32'(hi_if.out_valid),  32'h0);
    chk("t4_end_count", 32'(hi_if.word_count), 32'h7);

    // reset in the middle of BEEF
    hi_if.enable = 1'b1; hi_if.data_in = 16'hBEEF;
    tick();
    hi_if.enable = 1'b0;
    chk("t5_first", 32'(hi_if.data_out), 32'hBE);
    tick();
    chk("t5_second", 32'(hi_if.data_out), 32'hEF);
    reset = 1'b0;
    #1;
    chk("t5_rst_valid",  32'(hi_if.out_valid),  32'h0);
    chk("t5_rst_count",  32'(hi_if.word_count), 32'h0);
    chk("t5_rst_status", 32'(hi_if.status),     32'h0);
    chk("t5_rst_data",   32'(hi_if.data_out),   32'h00);
    chk("t5_rst_ready",  32'(hi_if.ready),      32'h0);
    chk("t5_rst_phase",  32'(hi_phase),         32'(PH_FIRST));
    reset = 1'b1;
    tick();
    chk("t5_ready_again", 32'(hi_if.ready), 32'h1);
    hi_if.enable = 1'b1; hi_if.data_in = 16'h0102;
    tick();
    hi_if.enable = 1'b0;
    chk("t5_new_first",  32'(hi_if.data_out), 32'h01);
    tick();
    chk("t5_new_second", 32'(hi_if.data_out), 32'h02);
    tick();
    chk("t5_new_count",  32'(hi_if.word_count), 32'h1);

    // counter wrap: 255 more words after the one above
    for (int i = 0; i < 255; i++) begin
      w = {8'(i), 8'(255 - i)};
      hi_if.enable = 1'b1; hi_if.data_in = w;
      tick();
      hi_if.enable = 1'b0;
      chk("t6_hi", 32'(hi_if.data_out), 32'(w[15:8]));
      tick();
    end
    chk("t6_count_ff", 32'(hi_if.word_count), 32'hFF);
    chk("t6_last_lo",  32'(hi_if.data_out),   32'h01);
    tick();
    chk("t6_count_wrap", 32'(hi_if.word_count), 32'h00);
    chk("t6_no_drop",    32'(hi_if.status),     32'h0);

`ifdef UNPACK_PARITY_EN
    hi_if.enable = 1'b1; hi_if.data_in = 16'h0700;
    tick();
    hi_if.enable = 1'b0;
    chk("t7_byte07",   32'(hi_if.data_out),   32'h07);
    chk("t7_par07",    32'(hi_if.out_parity), 32'h1);
    chk("t7_good_par", 32'(hi_if.status[ST_DROP]), 32'h0);
    tick();
    chk("t7_par00",    32'(hi_if.out_parity), 32'h0);
    tick();
    chk("t7_par_empty", 32'(hi_if.out_parity), 32'h0);
    par_flip = 1'b1;
    hi_if.enable = 1'b1; hi_if.data_in = 16'h0001;
    tick();
    hi_if.enable = 1'b0;
    par_flip = 1'b0;
    chk("t7_bad_par", 32'(hi_if.status[ST_DROP]), 32'h1);
    tick();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
